i2c_reg_access: RTL and testbench

Register-level sequencer between the HDMI transmitter configuration controller and the byte-level i2c_master (busy-handshake master, ena/addr/rw/data_wr/busy/data_rd/ack_error). It turns one command into a complete I2C transaction:
- write: START, chip+W, reg, value, STOP
- read: START, chip+W, reg, repeated START, chip+R, data, STOP

It reports completion, read data, NACK and timeout status, so the controller can poll ADV7513 status registers (HPD, PLL lock) as well as write configuration.

---
 rtl/i2c_reg_access.sv | 127 ++++++++++++
 tb/tb_i2c_reg_access.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_access.sv
// Register-level I2C sequencer: turns one write/read command into a complete
// byte-master transaction (chip+W, reg, then value or repeated-start read).
module i2c_reg_access #(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned TO_W           = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_chip,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       cmd_ready,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       ack_err,
  output logic       timeout,
  output logic       i2c_ena,
  output logic [6:0] i2c_addr,
  output logic       i2c_rw,
  output logic [7:0] i2c_data_wr,
  input  logic       i2c_busy,
  input  logic [7:0] i2c_data_rd,
  input  logic       i2c_ack_error
);

  typedef enum logic [1:0] {IDLE, B1, B2, FIN} state_t;

  state_t          state;
  logic            busy_q;
  logic            rw_q;
  logic [7:0]      wdata_q;
  logic [TO_W-1:0] to_cnt;

  logic busy_rise;
  logic busy_fall;
  logic fin_ok;
  logic abort;

  assign busy_rise = i2c_busy & ~busy_q;
  assign busy_fall = ~i2c_busy & busy_q;
  // Completion needs busy low for two samples so a one-cycle inter-byte gap is not mistaken for STOP.
  assign fin_ok    = (state == FIN) & ~i2c_busy & ~busy_q;
  // Completion in the same cycle as the timeout limit takes priority.
  assign abort     = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !fin_ok;

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch below reads the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      to_cnt      <= '0;
      cmd_ready   <= 1'b1;
      done        <= 1'b0;
      rd_data     <= '0;
      ack_err     <= 1'b0;
      timeout     <= 1'b0;
      i2c_ena     <= 1'b0;
      i2c_addr    <= '0;
      i2c_rw      <= 1'b0;
      i2c_data_wr <= '0;
    end else begin
      busy_q <= i2c_busy;
      done   <= 1'b0;

      if (state != IDLE) begin
        to_cnt <= to_cnt + TO_W'(1);
        if (busy_fall || fin_ok)
          ack_err <= ack_err | i2c_ack_error;
      end

      if (abort) begin
        i2c_ena <= 1'b0;
        timeout <= 1'b1;
        done    <= 1'b1;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_ready && cmd_valid) begin
              rw_q        <= cmd_rw;
              wdata_q     <= cmd_wdata;
              ack_err     <= 1'b0;
              timeout     <= 1'b0;
              to_cnt      <= '0;
              i2c_ena     <= 1'b1;
              i2c_addr    <= cmd_chip;
              i2c_rw      <= 1'b0;
              i2c_data_wr <= cmd_reg;
              cmd_ready   <= 1'b0;
              state       <= B1;
            end else begin
              cmd_ready <= 1'b1;
            end
          end
          B1: begin
            // Master has taken chip+W/reg; queue the second byte.
            if (busy_rise) begin
              if (rw_q) i2c_rw      <= 1'b1;
              else      i2c_data_wr <= wdata_q;
              state <= B2;
            end
          end
          B2: begin
            if (busy_rise) begin
              i2c_ena <= 1'b0;
              state   <= FIN;
            end
          end
          FIN: begin
            if (fin_ok) begin
              if (rw_q) rd_data <= i2c_data_rd;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_access.sv
// Directed bench for i2c_reg_access against a small behavioural byte-level
// I2C master model (busy handshake, per-byte latency, optional NACK / dead bus).
module tb_i2c_reg_access;

  localparam int         TO_CYC    = 100;
  localparam int         BYTE_CYC  = 9;
  localparam logic [6:0] NACK_CHIP = 7'h3A;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_chip = '0;
  logic [7:0] cmd_reg = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_ready, done, ack_err, timeout;
  logic [7:0] rd_data;
  logic       i2c_ena, i2c_rw;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_data_wr;
  logic       i2c_busy, i2c_ack_error;
  logic [7:0] i2c_data_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_reg_access #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_rw(cmd_rw), .cmd_chip(cmd_chip),
    .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .cmd_ready(cmd_ready),
    .done(done), .rd_data(rd_data), .ack_err(ack_err), .timeout(timeout),
    .i2c_ena(i2c_ena), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw),
    .i2c_data_wr(i2c_data_wr), .i2c_busy(i2c_busy),
    .i2c_data_rd(i2c_data_rd), .i2c_ack_error(i2c_ack_error)
  );

  // Master model: latches a command when idle or in the gap after a byte,
  // then runs a byte for BYTE_CYC cycles; STOP when ena is low in the gap.
  int         m_st = 0;
  int         m_cnt = 0;
  bit         m_dead = 1'b0;
  logic [7:0] m_rd_value = 8'h00;
  logic [6:0] m_addr_cur = '0;
  logic       m_rw_cur = 1'b0;
  logic [6:0] log_addr[$];
  logic       log_rw[$];
  logic [7:0] log_data[$];

  always @(posedge clk) begin
    if (!reset) begin
      i2c_busy      <= 1'b0;
      i2c_ack_error <= 1'b0;
      i2c_data_rd   <= '0;
      m_st          <= 0;
      m_cnt         <= 0;
    end else begin
      case (m_st)
        0, 2: begin
          if (i2c_ena && !m_dead) begin
            if (m_st == 0) i2c_ack_error <= 1'b0;
            m_addr_cur <= i2c_addr;
            m_rw_cur   <= i2c_rw;
            log_addr.push_back(i2c_addr);
            log_rw.push_back(i2c_rw);
            log_data.push_back(i2c_data_wr);
            i2c_busy <= 1'b1;
            m_cnt    <= 0;
            m_st     <= 1;
          end else if (m_st == 2) begin
            m_cnt <= 0;
            m_st  <= 3;
          end
        end
        1: begin
          if (m_cnt == BYTE_CYC - 1) begin
            i2c_busy <= 1'b0;
            m_st     <= 2;
            if (m_addr_cur == NACK_CHIP) i2c_ack_error <= 1'b1;
            if (m_rw_cur) i2c_data_rd <= m_rd_value;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
        3: begin
          if (m_cnt == 3) m_st <= 0;
          else m_cnt <= m_cnt + 1;
        end
        default: m_st <= 0;
      endcase
    end
  end

  // Event monitor sampled on the falling edge.
  int   cyc = 0;
  int   last_rise_cyc = -1;
  int   ena_fall_cyc = -1;
  int   done_cnt = 0;
  logic busy_prev = 1'b0;
  logic ena_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (i2c_busy === 1'b1 && busy_prev !== 1'b1) last_rise_cyc = cyc;
    if (i2c_ena === 1'b0 && ena_prev === 1'b1) ena_fall_cyc = cyc;
    if (done === 1'b1) done_cnt++;
    busy_prev = i2c_busy;
    ena_prev  = i2c_ena;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] log_d(input int i);
    return (i < log_data.size()) ? log_data[i] : 8'hxx;
  endfunction

  function automatic logic log_r(input int i);
    return (i < log_rw.size()) ? log_rw[i] : 1'bx;
  endfunction

  function automatic logic [6:0] log_a(input int i);
    return (i < log_addr.size()) ? log_addr[i] : 7'hxx;
  endfunction

  task automatic start_cmd(input logic rw, input logic [6:0] chip,
                           input logic [7:0] rg, input logic [7:0] wd);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin step(); n++; end
    cmd_rw    = rw;
    cmd_chip  = chip;
    cmd_reg   = rg;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin step(); n++; end
    check("done_seen", done, 1'b1);
  endtask

  initial begin
    int n, d0, l0;
    logic [7:0] b2b_reg[3];
    logic [7:0] b2b_val[3];
    b2b_reg = '{8'h9A, 8'h9C, 8'h9D};
    b2b_val = '{8'hE0, 8'h30, 8'h01};

    // Reset state
    reset = 1'b0;
    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_ena", i2c_ena, 1'b0);
    check("rst_addr", i2c_addr, 7'h00);
    check("rst_rw", i2c_rw, 1'b0);
    check("rst_data_wr", i2c_data_wr, 8'h00);
    reset = 1'b1;
    step();

    // Write 0x39 / reg 0x41 / value 0x10
    d0 = done_cnt;
    l0 = log_data.size();
    start_cmd(1'b0, 7'h39, 8'h41, 8'h10);
    check("wr_accept_ena", i2c_ena, 1'b1);
    check("wr_accept_addr", i2c_addr, 7'h39);
    check("wr_accept_rw", i2c_rw, 1'b0);
    check("wr_accept_data", i2c_data_wr, 8'h41);
    check("wr_accept_ready", cmd_ready, 1'b0);
    wait_done(200, n);
    check("wr_ack_err", ack_err, 1'b0);
    check("wr_timeout", timeout, 1'b0);
    check("wr_rd_data", rd_data, 8'h00);
    check("wr_ready_at_done", cmd_ready, 1'b0);
    step();
    check("wr_ready_after", cmd_ready, 1'b1);
    check("wr_done_pulse", done, 1'b0);
    check("wr_done_count", done_cnt - d0, 1);
    check("wr_bytes", log_data.size() - l0, 2);
    check("wr_byte1", log_d(l0), 8'h41);
    check("wr_byte2", log_d(l0 + 1), 8'h10);
    check("wr_ena_fall", ena_fall_cyc, last_rise_cyc + 1);

    // Read 0x39 / reg 0x42 -> 0x60
    m_rd_value = 8'h60;
    l0 = log_data.size();
    start_cmd(1'b1, 7'h39, 8'h42, 8'hFF);
    wait_done(200, n);
    check("rd_data", rd_data, 8'h60);
    check("rd_ack_err", ack_err, 1'b0);
    check("rd_rw1", log_r(l0), 1'b0);
    check("rd_reg", log_d(l0), 8'h42);
    check("rd_rw2", log_r(l0 + 1), 1'b1);
    check("rd_addr2", log_a(l0 + 1), 7'h39);
    step();

    // Absent chip: NACK, then a good write clears ack_err
    start_cmd(1'b0, NACK_CHIP, 8'h41, 8'h55);
    wait_done(200, n);
    check("nack_ack_err", ack_err, 1'b1);
    check("nack_timeout", timeout, 1'b0);
    check("nack_rd_data", rd_data, 8'h60);
    step();
    check("nack_ack_held", ack_err, 1'b1);
    start_cmd(1'b0, 7'h39, 8'h98, 8'h03);
    check("ack_cleared_accept", ack_err, 1'b0);
    wait_done(200, n);
    check("ack_after_good", ack_err, 1'b0);
    step();

    // Timeout: master never responds
    m_dead = 1'b1;
    start_cmd(1'b0, 7'h39, 8'h41, 8'h10);
    wait_done(300, n);
    check("to_cycles", n, TO_CYC);
    check("to_flag", timeout, 1'b1);
    check("to_ena", i2c_ena, 1'b0);
    check("to_ready_at_done", cmd_ready, 1'b0);
    check("to_rd_data", rd_data, 8'h60);
    step();
    check("to_ready_after", cmd_ready, 1'b1);
    check("to_done_pulse", done, 1'b0);
    check("to_flag_held", timeout, 1'b1);
    m_dead = 1'b0;

    // Reset between rise #1 and rise #2
    d0 = done_cnt;
    l0 = log_data.size();
    start_cmd(1'b0, 7'h39, 8'h41, 8'h22);
    check("rm_timeout_cleared", timeout, 1'b0);
    n = 0;
    while (log_data.size() < l0 + 1 && n < 100) begin step(); n++; end
    repeat (3) step();
    check("rm_second_byte_queued", i2c_data_wr, 8'h22);
    reset = 1'b0;
    step();
    check("rm_ena", i2c_ena, 1'b0);
    check("rm_ready", cmd_ready, 1'b1);
    check("rm_done", done, 1'b0);
    check("rm_rd_data", rd_data, 8'h00);
    reset = 1'b1;
    repeat (20) step();
    check("rm_no_done", done_cnt - d0, 0);
    check("rm_ena_idle", i2c_ena, 1'b0);
    start_cmd(1'b0, 7'h39, 8'h41, 8'h10);
    wait_done(200, n);
    check("rm_fresh_ack", ack_err, 1'b0);
    check("rm_fresh_timeout", timeout, 1'b0);
    step();

    // Back-to-back writes with cmd_valid held high
    d0 = done_cnt;
    l0 = log_data.size();
    cmd_valid = 1'b1;
    cmd_rw    = 1'b0;
    cmd_chip  = 7'h39;
    for (int i = 0; i < 3; i++) begin
      cmd_reg   = b2b_reg[i];
      cmd_wdata = b2b_val[i];
      n = 0;
      while (cmd_ready !== 1'b1 && n < 200) begin step(); n++; end
      step();
      check("b2b_accepted", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    wait_done(200, n);
    repeat (10) step();
    check("b2b_done_count", done_cnt - d0, 3);
    check("b2b_bytes", log_data.size() - l0, 6);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b_reg%0d", i), log_d(l0 + 2 * i), b2b_reg[i]);
      check($sformatf("b2b_val%0d", i), log_d(l0 + 2 * i + 1), b2b_val[i]);
    end
    check("b2b_idle_ready", cmd_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
